// File: rtl/bbfifo_16x8_ctrl.sv
// Pointer/count/flag control for a 16x8 register-file FIFO (UART TX/RX buffers).
// Latency: a write at edge N is visible on rdata_o right after edge N (FWFT).
// Backpressure: writes dropped while full (ovf_o), reads dropped while empty (udf_o).
//
// Ports:
//   clk, rst_n      clock, asynchronous active-low reset
//   clr_i           synchronous flush (pointers, count and sticky flags)
//   wr_i, wdata_i   write request and byte
//   rd_i            read request, pops the byte currently on rdata_o
//   rdata_o         head-of-FIFO byte, valid while empty_o==0
//   full_o, empty_o, half_full_o, count_o   occupancy status
//   ovf_o, udf_o    sticky overflow / underflow indications
//   mem_*           write port and read address to the external memory,
//                   mem_rdata_i is its combinational read data
module bbfifo_16x8_ctrl #(
  parameter int HALF_LVL = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       wr_i,
  input  logic [7:0] wdata_i,
  input  logic       rd_i,
  output logic [7:0] rdata_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       half_full_o,
  output logic [4:0] count_o,
  output logic       ovf_o,
  output logic       udf_o,
  output logic       mem_wen_o,
  output logic [7:0] mem_wdata_o,
  output logic [3:0] mem_waddr_o,
  output logic [3:0] mem_raddr_o,
  input  logic [7:0] mem_rdata_i
);

  localparam logic [4:0] HALF_CNT = 5'(HALF_LVL);
  localparam logic [4:0] DEPTH    = 5'd16;

  logic [3:0] wr_ptr;
  logic [3:0] rd_ptr;
  logic [4:0] count;
  logic       ovf;
  logic       udf;
  logic       full;
  logic       empty;
  logic       wr_acc;
  logic       rd_acc;

  // Status flags decode straight from the count register: no extra latency,
  // and no path from wr_i/rd_i into them.
  assign full  = (count == DEPTH);
  assign empty = (count == 5'd0);

  // A full FIFO still accepts a read and an empty one still accepts a write,
  // so simultaneous requests at the boundaries degrade to a single operation.
  assign wr_acc = wr_i & ~full  & ~clr_i;
  assign rd_acc = rd_i & ~empty & ~clr_i;

  // The write strobe is held low during reset so the memory is not touched
  // while the control state is being forced back to empty.
  assign mem_wen_o   = wr_acc & rst_n;
  assign mem_wdata_o = wdata_i;
  assign mem_waddr_o = wr_ptr;
  assign mem_raddr_o = rd_ptr;

  // FWFT: the memory read address is the registered rd_ptr, so rdata_o
  // depends only on state, never on the current cycle's requests.
  assign rdata_o     = mem_rdata_i;

  assign full_o      = full;
  assign empty_o     = empty;
  assign half_full_o = (count >= HALF_CNT);
  assign count_o     = count;
  assign ovf_o       = ovf;
  assign udf_o       = udf;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      count  <= 5'd0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else if (clr_i) begin
      // Memory contents are left as-is; only the bookkeeping is flushed.
      wr_ptr <= 4'd0;
      rd_ptr <= 4'd0;
      count  <= 5'd0;
      ovf    <= 1'b0;
      udf    <= 1'b0;
    end else begin
      // 4-bit pointers wrap 15->0 on their own.
      if (wr_acc) wr_ptr <= wr_ptr + 4'd1;
      if (rd_acc) rd_ptr <= rd_ptr + 4'd1;

      case ({wr_acc, rd_acc})
        2'b10:   count <= count + 5'd1;
        2'b01:   count <= count - 5'd1;
        default: count <= count;
      endcase

      if (wr_i && full)  ovf <= 1'b1;
      if (rd_i && empty) udf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_bbfifo_16x8_ctrl.sv
// Directed bench for bbfifo_16x8_ctrl with a behavioural 16x8 memory attached.
// Inputs change 1ns after the rising edge; outputs are sampled at that point.
// Every expected value below is written out by hand.
module tb_bbfifo_16x8_ctrl;

  logic       clk;
  logic       rst_n;
  logic       clr_i;
  logic       wr_i;
  logic [7:0] wdata_i;
  logic       rd_i;
  logic [7:0] rdata_o;
  logic       full_o;
  logic       empty_o;
  logic       half_full_o;
  logic [4:0] count_o;
  logic       ovf_o;
  logic       udf_o;
  logic       mem_wen_o;
  logic [7:0] mem_wdata_o;
  logic [3:0] mem_waddr_o;
  logic [3:0] mem_raddr_o;
  logic [7:0] mem_rdata_i;

  logic [7:0] mem [16];

  int errs;
  int checks;

  bbfifo_16x8_ctrl #(.HALF_LVL(8)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .clr_i       (clr_i),
    .wr_i        (wr_i),
    .wdata_i     (wdata_i),
    .rd_i        (rd_i),
    .rdata_o     (rdata_o),
    .full_o      (full_o),
    .empty_o     (empty_o),
    .half_full_o (half_full_o),
    .count_o     (count_o),
    .ovf_o       (ovf_o),
    .udf_o       (udf_o),
    .mem_wen_o   (mem_wen_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_waddr_o (mem_waddr_o),
    .mem_raddr_o (mem_raddr_o),
    .mem_rdata_i (mem_rdata_i)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Register-file memory: synchronous write, combinational read.
  always @(posedge clk) begin
    if (mem_wen_o) mem[mem_waddr_o] <= mem_wdata_o;
  end
  assign mem_rdata_i = mem[mem_raddr_o];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wr_i = 1'b0;
    rd_i = 1'b0;
    clr_i = 1'b0;
  endtask

  task automatic push(input logic [7:0] d);
    wr_i = 1'b1;
    wdata_i = d;
    step();
    wr_i = 1'b0;
  endtask

  task automatic flush();
    idle();
    clr_i = 1'b1;
    step();
    clr_i = 1'b0;
  endtask

  logic [7:0] exp_b;

  initial begin
    errs = 0;
    checks = 0;
    for (int i = 0; i < 16; i++) mem[i] = 8'h00;
    rst_n = 1'b0;
    clr_i = 1'b0;
    wr_i = 1'b0;
    rd_i = 1'b0;
    wdata_i = 8'h00;

    // Reset state
    #12;
    chk("rst_empty", empty_o, 1);
    chk("rst_full", full_o, 0);
    chk("rst_half", half_full_o, 0);
    chk("rst_count", count_o, 0);
    chk("rst_wen", mem_wen_o, 0);
    chk("rst_ovf", ovf_o, 0);
    chk("rst_udf", udf_o, 0);
    rst_n = 1'b1;
    step();

    // 1: fill with 0x00..0x0F, half_full from the 8th write
    for (int i = 0; i < 16; i++) begin
      wr_i = 1'b1;
      wdata_i = 8'(i);
      #1;
      chk("fill_wen", mem_wen_o, 1);
      step();
      chk("fill_count", count_o, i + 1);
      chk("fill_half", half_full_o, (i >= 7) ? 1 : 0);
    end
    idle();
    chk("fill_full", full_o, 1);
    chk("fill_ovf", ovf_o, 0);

    // 2: write while full is dropped and flagged
    wr_i = 1'b1;
    wdata_i = 8'hAA;
    #1;
    chk("ovf_wen", mem_wen_o, 0);
    step();
    idle();
    chk("ovf_flag", ovf_o, 1);
    chk("ovf_count", count_o, 16);
    chk("ovf_head", rdata_o, 8'h00);

    // 3: drain in order, then underflow
    for (int i = 0; i < 16; i++) begin
      chk("drain_data", rdata_o, i);
      rd_i = 1'b1;
      step();
    end
    idle();
    chk("drain_empty", empty_o, 1);
    chk("drain_ovf_sticky", ovf_o, 1);
    rd_i = 1'b1;
    step();
    idle();
    chk("udf_flag", udf_o, 1);
    chk("udf_count", count_o, 0);
    flush();
    chk("clr_ovf", ovf_o, 0);
    chk("clr_udf", udf_o, 0);

    // 4: 40 bytes streamed through with overlapping write/read (pointers wrap twice)
    push(8'd0);
    for (int i = 1; i < 40; i++) begin
      wr_i = 1'b1;
      rd_i = 1'b1;
      wdata_i = 8'(i);
      chk("wrap_data", rdata_o, i - 1);
      step();
      chk("wrap_count", count_o, 1);
    end
    idle();
    chk("wrap_last", rdata_o, 39);
    rd_i = 1'b1;
    step();
    idle();
    chk("wrap_empty", empty_o, 1);

    // 5a: simultaneous write/read at count 5
    flush();
    for (int i = 0; i < 5; i++) push(8'h50 + 8'(i));
    wr_i = 1'b1;
    rd_i = 1'b1;
    wdata_i = 8'h55;
    chk("sim5_head", rdata_o, 8'h50);
    step();
    idle();
    chk("sim5_count", count_o, 5);
    chk("sim5_next", rdata_o, 8'h51);

    // 5b: at full the read wins, write dropped
    for (int i = 0; i < 11; i++) push(8'h56 + 8'(i));
    chk("simf_full", full_o, 1);
    wr_i = 1'b1;
    rd_i = 1'b1;
    wdata_i = 8'hEE;
    #1;
    chk("simf_wen", mem_wen_o, 0);
    step();
    idle();
    chk("simf_count", count_o, 15);
    chk("simf_ovf", ovf_o, 1);
    chk("simf_head", rdata_o, 8'h52);

    // 5c: at empty the write wins, read dropped, byte falls through
    flush();
    wr_i = 1'b1;
    rd_i = 1'b1;
    wdata_i = 8'h77;
    #1;
    chk("sime_wen", mem_wen_o, 1);
    step();
    idle();
    chk("sime_count", count_o, 1);
    chk("sime_udf", udf_o, 1);
    chk("sime_data", rdata_o, 8'h77);
    chk("sime_empty", empty_o, 0);

    // 6: flush at count 9 with a write pending; mem[9] still holds 0x59
    for (int i = 0; i < 8; i++) push(8'h80 + 8'(i));
    chk("clr_pre_count", count_o, 9);
    clr_i = 1'b1;
    wr_i = 1'b1;
    wdata_i = 8'h99;
    #1;
    chk("clr_wen", mem_wen_o, 0);
    step();
    idle();
    chk("clr_count", count_o, 0);
    chk("clr_empty", empty_o, 1);
    chk("clr_udf2", udf_o, 0);
    chk("clr_ovf2", ovf_o, 0);
    exp_b = mem[9];
    chk("clr_nowrite", exp_b, 8'h59);

    // Reset asserted between edges during a write burst
    push(8'h31);
    push(8'h32);
    wr_i = 1'b1;
    wdata_i = 8'h33;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst_count", count_o, 0);
    chk("arst_empty", empty_o, 1);
    chk("arst_wen", mem_wen_o, 0);
    step();
    chk("arst_hold", count_o, 0);
    idle();
    #2;
    rst_n = 1'b1;
    step();
    push(8'h44);
    chk("post_rst_data", rdata_o, 8'h44);
    chk("post_rst_count", count_o, 1);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
